// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - serial x^7+x^6+1 LFSR sequence checker with flywheel lock (optional period check: LFSR_SEQ_CHECKER_PERIOD_EN)
module lfsr_seq_checker #(
  parameter int MISS_LIMIT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             period_ok,
  output logic             period_err
);

  typedef enum logic {SEED = 1'b0, LOCKED = 1'b1} state_t;

  localparam logic [2:0] MISS_LIM3 = 3'(MISS_LIMIT);

  state_t           state_q;
  logic [6:0]       w_q;
  logic [2:0]       seed_cnt_q;
  logic [2:0]       miss_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_count_q;

  logic       predict;
  logic       mismatch;
  logic [6:0] w_seed_d;
  logic [6:0] w_fly_d;
  logic [2:0] miss_d;
  logic       enter_lock;
  logic       drop_lock;

  // Prediction from the two oldest window bits, and the two candidate next windows
  always_comb begin
    predict    = w_q[6] ^ w_q[5];
    mismatch   = in_bit ^ predict;
    w_seed_d   = {w_q[5:0], in_bit};
    w_fly_d    = {w_q[5:0], predict};
    miss_d     = miss_q + 3'd1;
    enter_lock = in_valid && (state_q == SEED) && (seed_cnt_q == 3'd6) && (w_seed_d != 7'd0);
    drop_lock  = in_valid && (state_q == LOCKED) && mismatch && (miss_d == MISS_LIM3);
  end

  // Seed/lock FSM with registered lock flag, error pulse and saturating error count
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= SEED;
      w_q         <= 7'd0;
      seed_cnt_q  <= 3'd0;
      miss_q      <= 3'd0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (in_valid) begin
        if (state_q == SEED) begin
          w_q <= w_seed_d;
          if (seed_cnt_q == 3'd6) begin
            // An all-zero seed can never advance, so it is discarded and seeding restarts
            seed_cnt_q <= 3'd0;
            if (enter_lock) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              miss_q   <= 3'd0;
            end
          end else begin
            seed_cnt_q <= seed_cnt_q + 3'd1;
          end
        end else begin
          // Flywheel: the window follows the prediction so a corrupted bit cannot poison it
          w_q <= w_fly_d;
          if (mismatch) begin
            err_pulse_q <= 1'b1;
            if (!(&err_count_q)) begin
              err_count_q <= err_count_q + ERR_W'(1);
            end
            if (drop_lock) begin
              state_q    <= SEED;
              locked_q   <= 1'b0;
              miss_q     <= 3'd0;
              seed_cnt_q <= 3'd0;
            end else begin
              miss_q <= miss_d;
            end
          end else begin
            miss_q <= 3'd0;
          end
        end
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
  logic [6:0] ref_w_q;
  logic [6:0] per_cnt_q;
  logic       period_ok_q;
  logic       period_err_q;

  // After 127 locked bits the flywheel window must return to the window captured at lock
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ref_w_q      <= 7'd0;
      per_cnt_q    <= 7'd0;
      period_ok_q  <= 1'b0;
      period_err_q <= 1'b0;
    end else begin
      period_ok_q  <= 1'b0;
      period_err_q <= 1'b0;
      if (enter_lock) begin
        ref_w_q   <= w_seed_d;
        per_cnt_q <= 7'd0;
      end else if (drop_lock) begin
        per_cnt_q <= 7'd0;
      end else if (in_valid && (state_q == LOCKED)) begin
        if (per_cnt_q == 7'd126) begin
          per_cnt_q <= 7'd0;
          if (w_fly_d == ref_w_q) begin
            period_ok_q <= 1'b1;
          end else begin
            period_err_q <= 1'b1;
          end
        end else begin
          per_cnt_q <= per_cnt_q + 7'd1;
        end
      end
    end
  end

  assign period_ok  = period_ok_q;
  assign period_err = period_err_q;
`else
  assign period_ok  = 1'b0;
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb/tb_lfsr_seq_checker.sv - directed self-checking bench for lfsr_seq_checker
module tb_lfsr_seq_checker;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;

  logic       locked, err_pulse, period_ok, period_err;
  logic [7:0] err_count;
  logic       m1_locked, m1_err_pulse, m1_period_ok, m1_period_err;
  logic [7:0] m1_err_count;
  logic       m7_locked, m7_err_pulse, m7_period_ok, m7_period_err;
  logic [7:0] m7_err_count;

  lfsr_seq_checker u_dut (
    .clock(clock), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .period_ok(period_ok), .period_err(period_err)
  );

  lfsr_seq_checker #(.MISS_LIMIT(1), .ERR_W(8)) u_m1 (
    .clock(clock), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
    .locked(m1_locked), .err_pulse(m1_err_pulse), .err_count(m1_err_count),
    .period_ok(m1_period_ok), .period_err(m1_period_err)
  );

  lfsr_seq_checker #(.MISS_LIMIT(7), .ERR_W(8)) u_m7 (
    .clock(clock), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
    .locked(m7_locked), .err_pulse(m7_err_pulse), .err_count(m7_err_count),
    .period_ok(m7_period_ok), .period_err(m7_period_err)
  );

  always #5 clock = ~clock;

`ifdef LFSR_SEQ_CHECKER_PERIOD_EN
  localparam int POK400 = 3;
`else
  localparam int POK400 = 0;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses, pok, perr, aux;
  logic s [0:2047];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic v);
    in_bit   = b;
    in_valid = v;
    @(posedge clock);
    #1;
    pulses += int'(err_pulse);
    pok    += int'(period_ok);
    perr   += int'(period_err) + int'(m1_period_err) + int'(m7_period_err);
    aux    += int'(m1_err_pulse) + int'(m7_err_pulse) + int'(m1_period_ok) + int'(m7_period_ok);
  endtask

  task automatic do_reset();
    clear    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    @(posedge clock);
    #1;
    clear  = 1'b0;
    pulses = 0;
    pok    = 0;
    perr   = 0;
  endtask

  initial begin
    int cnt;
    logic at50;
    s[0] = 1'b0; s[1] = 1'b0; s[2] = 1'b1; s[3] = 1'b0;
    s[4] = 1'b0; s[5] = 1'b0; s[6] = 1'b0;
    for (int n = 7; n < 2048; n++) s[n] = s[n-7] ^ s[n-6];
    pulses = 0; pok = 0; perr = 0; aux = 0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_locked", locked, 0);
    check_val("rst_err_pulse", err_pulse, 0);
    check_val("rst_err_count", err_count, 0);
    check_val("rst_period_ok", period_ok, 0);
    check_val("rst_period_err", period_err, 0);
    clear = 1'b0;

    // reference stream, continuous valid
    for (int i = 0; i < 6; i++) step(s[i], 1'b1);
    check_val("ref_lock_6th", locked, 0);
    step(s[6], 1'b1);
    check_val("ref_lock_7th", locked, 1);
    cnt = 0;
    for (int i = 7; i < 400; i++) begin
      step(s[i], 1'b1);
      if (!locked) cnt++;
    end
    check_val("ref_unlocked_cycles", cnt, 0);
    check_val("ref_err_count", err_count, 0);
    check_val("ref_err_pulses", pulses, 0);
    check_val("ref_period_ok", pok, POK400);
    check_val("ref_period_err", perr, 0);

    // single corrupted bit at index 50
    do_reset();
    at50 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(s[i] ^ (i == 50), 1'b1);
      if (i == 50) at50 = err_pulse;
    end
    check_val("flip_pulse_at50", at50, 1);
    check_val("flip_pulses", pulses, 1);
    check_val("flip_err_count", err_count, 1);
    check_val("flip_locked", locked, 1);
    check_val("flip_period_ok", pok, POK400);
    check_val("flip_period_err", perr, 0);

    // inverted stream after lock
    do_reset();
    for (int i = 0; i < 20; i++) step(s[i], 1'b1);
    check_val("inv_locked_before", locked, 1);
    step(~s[20], 1'b1);
    check_val("inv1_locked", locked, 1);
    check_val("inv1_m1_locked", m1_locked, 0);
    check_val("inv1_m1_err_count", m1_err_count, 1);
    step(~s[21], 1'b1);
    check_val("inv2_locked", locked, 1);
    check_val("inv2_err_count", err_count, 2);
    step(~s[22], 1'b1);
    check_val("inv3_locked", locked, 0);
    check_val("inv3_err_count", err_count, 3);
    check_val("inv3_err_pulse", err_pulse, 1);

    // all-zero input never locks
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1);
      if (locked) cnt++;
    end
    check_val("zero_locked_cycles", cnt, 0);
    check_val("zero_err_count", err_count, 0);

    // reference stream with idle cycles between valid bits
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step(s[k], 1'b1);
      step(~s[k], 1'b0);
    end
    check_val("gap_lock_6th", locked, 0);
    step(s[6], 1'b1);
    check_val("gap_lock_7th", locked, 1);
    step(1'b1, 1'b0);
    check_val("gap_lock_idle", locked, 1);
    for (int k = 7; k < 100; k++) begin
      step(s[k], 1'b1);
      step(~s[k], 1'b0);
    end
    check_val("gap_err_count", err_count, 0);
    check_val("gap_err_pulses", pulses, 0);
    check_val("gap_locked_end", locked, 1);

    // saturation, then asynchronous clear mid-lock
    do_reset();
    for (int i = 0; i < 7; i++) step(s[i], 1'b1);
    for (int i = 7; i < 607; i++) step(~s[i], 1'b1);
    check_val("sat_m7_err_count", m7_err_count, 255);
    for (int i = 607; i < 907; i++) step(s[i], 1'b1);
    check_val("sat_relock_main", locked, 1);
    check_val("sat_relock_m7", m7_locked, 1);
    check_val("sat_kept_m7_count", m7_err_count, 255);
    #2;
    clear = 1'b1;
    #1;
    check_val("aclr_locked", locked, 0);
    check_val("aclr_m7_locked", m7_locked, 0);
    check_val("aclr_err_count", err_count, 0);
    check_val("aclr_m7_err_count", m7_err_count, 0);
    check_val("aclr_err_pulse", err_pulse, 0);
    check_val("aclr_period_ok", period_ok, 0);
    #1;
    clear = 1'b0;
    for (int i = 0; i < 6; i++) step(s[i], 1'b1);
    check_val("aclr_relock_6th", locked, 0);
    step(s[6], 1'b1);
    check_val("aclr_relock_7th", locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
